// File: rtl/addr_gen_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : addr_gen_ctrl_pkg
//  Description : Shared types and default widths for the 2-D address
//                generator (FSM state encoding, widths of the config and
//                accumulator paths).
//  Revision    : 1.0 - initial release
// ============================================================================
package addr_gen_ctrl_pkg;

    localparam int ADDR_W_DEFAULT = 16;  // emitted address width
    localparam int CNT_W_DEFAULT  = 32;  // x/y bound and counter width
    localparam int ACC_W          = 32;  // stride accumulator width (wraps mod 2^32)
    localparam int XSTRIDE_W      = 16;  // width of the in-row stride

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } agc_state_e;

endpackage : addr_gen_ctrl_pkg
`default_nettype wire

// File: rtl/addr_gen_ctrl_counter2d.sv
`default_nettype none
// ============================================================================
//  Module      : agc_counter2d
//  Description : Row-major x/y counter pair with a 32-bit stride
//                accumulator. x steps by x_stride inside a row; at a row
//                end x wraps to 0, y increments and the accumulator steps
//                by y_stride instead of x_stride.
//  Revision    : 1.0 - initial release
// ============================================================================
module agc_counter2d
    import addr_gen_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_clear,
    input  logic                 i_step,
    input  logic [CNT_W-1:0]     i_x_max,
    input  logic [CNT_W-1:0]     i_y_max,
    input  logic [XSTRIDE_W-1:0] i_x_stride,
    input  logic [ACC_W-1:0]     i_y_stride,
    output logic [ACC_W-1:0]     o_acc,
    output logic                 o_last
);

    localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

    logic [CNT_W-1:0] r_x_cnt;
    logic [CNT_W-1:0] r_y_cnt;
    logic [ACC_W-1:0] r_acc;
    logic             w_row_end;
    logic             w_col_end;
    logic [ACC_W-1:0] w_x_stride_ext;

    // Row / column terminal detection and zero-extended in-row stride
    always_comb begin
        w_row_end      = (r_x_cnt == (i_x_max - c_one));
        w_col_end      = (r_y_cnt == (i_y_max - c_one));
        w_x_stride_ext = {{(ACC_W-XSTRIDE_W){1'b0}}, i_x_stride};
    end

    // Counters and accumulator advance only on an accepted beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x_cnt <= '0;
            r_y_cnt <= '0;
            r_acc   <= '0;
        end else if (i_clear) begin
            r_x_cnt <= '0;
            r_y_cnt <= '0;
            r_acc   <= '0;
        end else if (i_step) begin
            if (w_row_end) begin
                r_x_cnt <= '0;
                r_y_cnt <= r_y_cnt + c_one;
                r_acc   <= r_acc + i_y_stride;
            end else begin
                r_x_cnt <= r_x_cnt + c_one;
                r_acc   <= r_acc + w_x_stride_ext;
            end
        end
    end

    assign o_acc  = r_acc;
    assign o_last = w_row_end && w_col_end;

endmodule : agc_counter2d
`default_nettype wire

// File: rtl/addr_gen_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : addr_gen_ctrl
//  Description : 2-D strided address generator. Accepts a scan
//                configuration in IDLE, streams offset+acc addresses with a
//                valid/ready handshake in RUN, pulses done for one cycle in
//                DONE. Supports abort and back-pressure. ADDR_W must not
//                exceed 32 (the accumulator width).
//  Revision    : 1.0 - initial release
// ============================================================================
module addr_gen_ctrl
    import addr_gen_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int CNT_W  = CNT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CNT_W-1:0]  cfg_x_max,
    input  logic [CNT_W-1:0]  cfg_y_max,
    input  logic [15:0]       cfg_x_stride,
    input  logic [31:0]       cfg_y_stride,
    input  logic [31:0]       cfg_offset,
    input  logic              abort,
    output logic              addr_valid,
    input  logic              addr_ready,
    output logic [ADDR_W-1:0] addr,
    output logic              addr_last,
    output logic              busy,
    output logic              done
);

    agc_state_e              r_state;
    agc_state_e              w_state_nxt;
    logic                    w_cfg_accept;
    logic                    w_step;
    logic                    w_last;
    logic [ACC_W-1:0]        w_acc;

    logic [CNT_W-1:0]        r_x_max;
    logic [CNT_W-1:0]        r_y_max;
    logic [XSTRIDE_W-1:0]    r_x_stride;
    logic [ACC_W-1:0]        r_y_stride;
    logic [ACC_W-1:0]        r_offset;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake decode; a zero extent skips straight to DONE
    always_comb begin
        w_state_nxt  = r_state;
        w_cfg_accept = 1'b0;
        cfg_ready    = 1'b0;
        addr_valid   = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    w_cfg_accept = 1'b1;
                    if ((cfg_x_max == '0) || (cfg_y_max == '0)) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                addr_valid = 1'b1;
                busy       = 1'b1;
                if (abort || (addr_ready && w_last)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Configuration capture on the cfg handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x_max    <= '0;
            r_y_max    <= '0;
            r_x_stride <= '0;
            r_y_stride <= '0;
            r_offset   <= '0;
        end else if (w_cfg_accept) begin
            r_x_max    <= cfg_x_max;
            r_y_max    <= cfg_y_max;
            r_x_stride <= cfg_x_stride;
            r_y_stride <= cfg_y_stride;
            r_offset   <= cfg_offset;
        end
    end

    // Only an accepted beat moves the counters; an aborting beat still counts
    assign w_step = (r_state == ST_RUN) && addr_ready;

    agc_counter2d #(
        .CNT_W      (CNT_W)
    ) u_counter2d (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_cfg_accept),
        .i_step     (w_step),
        .i_x_max    (r_x_max),
        .i_y_max    (r_y_max),
        .i_x_stride (r_x_stride),
        .i_y_stride (r_y_stride),
        .o_acc      (w_acc),
        .o_last     (w_last)
    );

    // Address is offset+acc truncated after the add; forced to 0 outside RUN
    always_comb begin
        addr      = '0;
        addr_last = 1'b0;
        if (r_state == ST_RUN) begin
            addr      = ADDR_W'(r_offset + w_acc);
            addr_last = w_last;
        end
    end

endmodule : addr_gen_ctrl
`default_nettype wire
